reset_sequencer: RTL



---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // Width of a counter that must reach the largest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/request inputs and staged reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_W      = 8
);
  logic                  locked;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  all_released;
  logic [CNT_W-1:0]      lock_loss_cnt;
  logic [2:0]            state;

  modport master (
    input  locked, sw_rst_req,
    output stage_rst_n, all_released, lock_loss_cnt, state
  );

  modport slave (
    output locked, sw_rst_req,
    input  stage_rst_n, all_released, lock_loss_cnt, state
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Gates on PLL lock, holds reset, then releases active-low reset domains in
// order with a fixed gap; re-asserts all on lock loss or software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned MIN_ASSERT  = 4,
  parameter int unsigned HOLD_CYCLES = 65535,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  reset_sequencer_if.master   bus
);

  localparam int unsigned CW = cnt_width(MIN_ASSERT, HOLD_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  logic                  locked_s;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  all_rel_q, all_rel_d;
  logic [CNT_W-1:0]      loss_q, loss_d;
  logic [NUM_STAGES-1:0] stage_next;
  logic                  restart;
  logic                  lost;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

  // Released bits fill contiguously from bit 0, so the next release is a shift-in of a one.
  assign stage_next = NUM_STAGES'({stage_q, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      stage_q   <= '0;
      all_rel_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      loss_q    <= loss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    all_rel_d = all_rel_q;
    loss_d    = loss_q;
    restart   = 1'b0;
    lost      = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        stage_d   = '0;
        all_rel_d = 1'b0;
        if (cnt_q == MIN_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      // A lock drop here is still power-up settling, not a counted loss.
      ST_HOLD: begin
        if (bus.sw_rst_req) begin
          restart = 1'b1;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          stage_d = stage_next;
          if (&stage_next) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end

      ST_RELEASE: begin
        if (!locked_s) begin
          lost    = 1'b1;
          restart = 1'b1;
        end else if (bus.sw_rst_req) begin
          restart = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          stage_d = stage_next;
          if (&stage_next) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          lost    = 1'b1;
          restart = 1'b1;
        end else if (bus.sw_rst_req) begin
          restart = 1'b1;
        end
      end

      default: restart = 1'b1;
    endcase

    if (restart) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      stage_d   = '0;
      all_rel_d = 1'b0;
    end

    if (lost && (loss_q != '1)) begin
      loss_d = CNT_W'(loss_q + 1'b1);
    end
  end

  assign bus.stage_rst_n   = stage_q;
  assign bus.all_released  = all_rel_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.state         = state_q;

endmodule
